// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and counter sizing for the digit-serial adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/digit_add.sv
// digit_add: DIGIT-bit combinational adder with carry-out and carry into its MSB
module digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [DIGIT:0] full;
  assign full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
  assign s    = full[DIGIT-1:0];
  assign co   = full[DIGIT];
  assign cm   = a[DIGIT-1] ^ b[DIGIT-1] ^ s[DIGIT-1];
endmodule

// File: rtl/addn_digit_serial.sv
// addn_digit_serial: multi-cycle adder summing DIGIT bits per clock with start/busy/done and signed overflow
module addn_digit_serial
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(N);
  if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("addn_digit_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  state_t           st, nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res, nres;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d;
  logic             carry, c, cm, last, load;
  digit_add #(.DIGIT(DIGIT)) u_add (
    .a (a_sr[DIGIT-1:0]),
    .b (b_sr[DIGIT-1:0]),
    .ci(carry),
    .s (d),
    .co(c),
    .cm(cm)
  );
  assign nres = WIDTH'({d, res} >> DIGIT);
  assign last = st == RUN && cnt == CW'(N - 1);
  assign load = start && st != RUN;
  always_comb begin
    nxt  = st == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    busy = st == RUN;
    done = st == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      ovf   <= 1'b0;
    end else begin
      st <= nxt;
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (st == RUN) begin
        a_sr  <= a_sr >> DIGIT;
        b_sr  <= b_sr >> DIGIT;
        res   <= nres;
        carry <= c;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum <= {c, nres};
          ovf <= cm ^ c;
        end
      end
    end
  end
endmodule

// File: tb/tb_addn_digit_serial.sv
// tb_addn_digit_serial: self-checking bench for addn_digit_serial against an arithmetic reference
module tb_addn_digit_serial;
  logic       clk = 1'b0;
  logic       reset, start3, cin3, start8, cin8;
  logic [2:0] a3, b3;
  logic [7:0] a8, b8;
  logic       busy3, done3, ovf3, busy8, done8, ovf8, busyf, donef, ovff;
  logic [3:0] sum3;
  logic [8:0] sum8, sumf;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  addn_digit_serial #(.WIDTH(3), .DIGIT(1)) u3 (
    .clk(clk), .reset(reset), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .ovf(ovf3)
  );
  addn_digit_serial #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .ovf(ovf8)
  );
  addn_digit_serial #(.WIDTH(8), .DIGIT(8)) u8f (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busyf), .done(donef), .sum(sumf), .ovf(ovff)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic ovf_ref(input int w, input int x, input int y, input int c);
    int sx, sy, s;
    sx = x >= (1 << (w - 1)) ? x - (1 << w) : x;
    sy = y >= (1 << (w - 1)) ? y - (1 << w) : y;
    s  = sx + sy + c;
    return s > (1 << (w - 1)) - 1 || s < -(1 << (w - 1));
  endfunction
  task automatic go3(input logic [2:0] x, input logic [2:0] y, input logic c);
    a3 = x;
    b3 = y;
    cin3 = c;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
  endtask
  task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic c);
    a8 = x;
    b8 = y;
    cin8 = c;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask
  task automatic wait3(input int n0, output int n);
    n = n0;
    while (!done3 && n < 20) begin
      tick();
      n++;
    end
  endtask
  task automatic wait8(input int n0, output int n);
    n = n0;
    while (!done8 && n < 20) begin
      tick();
      n++;
    end
  endtask
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [8:0] es, input logic eo);
    int n;
    go8(x, y, c);
    wait8(1, n);
    check("t2_latency", 32'(n), 32'd5);
    check("t2_sum", 32'(sum8), 32'(es));
    check("t2_ovf", 32'(ovf8), 32'(eo));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n, bc, cnt_done, c;
    logic [7:0] x, y;
    reset = 1'b1;
    start3 = 1'b0;
    start8 = 1'b0;
    a3 = '0; b3 = '0; cin3 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    tick();
    tick();
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_ovf8", 32'(ovf8), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    check("rst_sum3", 32'(sum3), 32'd0);
    check("rst_sumf", 32'(sumf), 32'd0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int k = 0; k < 2; k++) begin
          go3(3'(i), 3'(j), 1'(k));
          wait3(1, n);
          check("t1_latency", 32'(n), 32'd4);
          check("t1_sum", 32'(sum3), 32'(i + j + k));
          check("t1_ovf", 32'(ovf3), 32'(ovf_ref(3, i, j, k)));
        end
    run8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    run8(8'h80, 8'h80, 1'b0, 9'h100, 1'b1);
    repeat (40) begin
      x = 8'($urandom);
      y = 8'($urandom);
      c = int'($urandom_range(0, 1));
      go8(x, y, 1'(c));
      check("rnd_busyf", 32'(busyf), 32'd1);
      tick();
      check("rnd_donef", 32'(donef), 32'd1);
      check("rnd_sumf", 32'(sumf), 32'(int'(x) + int'(y) + c));
      check("rnd_ovff", 32'(ovff), 32'(ovf_ref(8, int'(x), int'(y), c)));
      wait8(2, n);
      check("rnd_latency", 32'(n), 32'd5);
      check("rnd_sum", 32'(sum8), 32'(int'(x) + int'(y) + c));
      check("rnd_ovf", 32'(ovf8), 32'(ovf_ref(8, int'(x), int'(y), c)));
    end
    tick();
    go8(8'd3, 8'd5, 1'b1);
    bc = 0;
    n = 1;
    while (busy8 && n < 20) begin
      bc++;
      tick();
      n++;
    end
    check("t3_busy_cycles", 32'(bc), 32'd4);
    check("t3_done", 32'(done8), 32'd1);
    check("t3_busy_at_done", 32'(busy8), 32'd0);
    check("t3_sum", 32'(sum8), 32'd9);
    tick();
    check("t3_done_pulse", 32'(done8), 32'd0);
    check("t3_sum_hold", 32'(sum8), 32'd9);
    tick();
    check("t3_sum_hold2", 32'(sum8), 32'd9);
    go8(8'd10, 8'd20, 1'b0);
    tick();
    a8 = 8'd1;
    b8 = 8'd1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait8(3, n);
    check("t4_latency", 32'(n), 32'd5);
    check("t4_sum", 32'(sum8), 32'd30);
    cnt_done = 0;
    repeat (8) begin
      tick();
      if (done8 || busy8) cnt_done++;
    end
    check("t4_ignored", 32'(cnt_done), 32'd0);
    go8(8'd50, 8'd60, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_done", 32'(done8), 32'd0);
    check("t5_sum", 32'(sum8), 32'd0);
    check("t5_ovf", 32'(ovf8), 32'd0);
    cnt_done = 0;
    repeat (8) begin
      tick();
      if (done8) cnt_done++;
    end
    check("t5_no_done", 32'(cnt_done), 32'd0);
    go8(8'd50, 8'd60, 1'b0);
    wait8(1, n);
    check("t6_first_sum", 32'(sum8), 32'd110);
    a8 = 8'd100;
    b8 = 8'd27;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t6_restart_busy", 32'(busy8), 32'd1);
    wait8(1, n);
    check("t6_latency", 32'(n), 32'd5);
    check("t6_sum", 32'(sum8), 32'd127);
    check("t6_ovf", 32'(ovf8), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
